// File: rtl/simple_bus_if.sv
// Request/response handshake and simple-bus channels between a command source,
// simple_bus_master and a bus responder.
interface simple_bus_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_write;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wr_en;
    logic                  wr_ready;
    logic [ADDR_WIDTH-1:0] raddr;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rd_ready;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready,
        output rsp_valid, rsp_write, rsp_rdata, rsp_err,
        input  rsp_ready,
        output waddr, wdata, wr_en, raddr, rd_en,
        input  wr_ready, rdata, rd_ready
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_write, rsp_rdata, rsp_err,
        output rsp_ready,
        input  waddr, wdata, wr_en, raddr, rd_en,
        output wr_ready, rdata, rd_ready
    );
endinterface

// File: rtl/simple_bus_master.sv
// Simple-bus initiator: buffers read/write commands in a FIFO and issues them one at a
// time, returning one response per command (read data or timeout error).
module simple_bus_master #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    simple_bus_if.master                bus,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    // Timer value at the edge where it would reach TIMEOUT_CYCLES-1
    localparam logic [TMR_W-1:0] TMR_TRIP = TMR_W'(TIMEOUT_CYCLES - 2);

    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } cmd_t;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_RESP} state_t;

    state_t                state_q, state_d;
    cmd_t                  fifo_mem [FIFO_DEPTH];
    cmd_t                  head;
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  push, pop;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic                  cmd_write_q, cmd_write_d;
    logic                  wr_en_q, wr_en_d, rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d, raddr_q, raddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  busy_q, busy_d;

    assign bus.req_ready = (count_q < DEPTH_C);
    assign push          = bus.req_valid && bus.req_ready;
    assign head          = fifo_mem[rd_ptr_q];

    // Command storage; no reset needed, occupancy is tracked by count_q
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= cmd_t'({bus.req_write, bus.req_addr, bus.req_wdata});
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        cmd_write_d = cmd_write_q;
        wr_en_d     = wr_en_q;
        rd_en_d     = rd_en_q;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        raddr_d     = raddr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        pop         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    pop         = 1'b1;
                    state_d     = ST_ISSUE;
                    timer_d     = '0;
                    cmd_write_d = head.write;
                    if (head.write) begin
                        wr_en_d = 1'b1;
                        waddr_d = head.addr;
                        wdata_d = head.wdata;
                    end else begin
                        rd_en_d = 1'b1;
                        raddr_d = head.addr;
                    end
                end
            end
            ST_ISSUE: begin
                timer_d = timer_q + TMR_W'(1);
                // Only the ready of the channel in use counts
                if (cmd_write_q ? bus.wr_ready : bus.rd_ready) begin
                    wr_en_d     = 1'b0;
                    rd_en_d     = 1'b0;
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = cmd_write_q;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = cmd_write_q ? '0 : bus.rdata;
                end else if (timer_q == TMR_TRIP) begin
                    wr_en_d     = 1'b0;
                    rd_en_d     = 1'b0;
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = cmd_write_q;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE) || (count_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            timer_q     <= '0;
            cmd_write_q <= 1'b0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            raddr_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
            rd_ptr_q    <= pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
            count_q     <= count_d;
            timer_q     <= timer_d;
            cmd_write_q <= cmd_write_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            raddr_q     <= raddr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.wr_en     = wr_en_q;
    assign bus.rd_en     = rd_en_q;
    assign bus.waddr     = waddr_q;
    assign bus.wdata     = wdata_q;
    assign bus.raddr     = raddr_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_write = rsp_write_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign busy          = busy_q;
    assign fifo_count    = count_q;
endmodule
